// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencing for a five-stage pipeline with load-use detection,
// branch/jump flushes, data-memory wait freezing, sticky memory timeout and a saturating stall counter.
module pipeline_hazard_ctrl #(
    parameter int MEM_WAIT_MAX = 15,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             MemRead_EX_i,
    input  logic [4:0]       Rw_EX_i,
    input  logic [4:0]       Rs_ID_i,
    input  logic [4:0]       Rt_ID_i,
    input  logic             Branch_EX_i,
    input  logic             Jump_ID_i,
    input  logic             mem_req_MEM_i,
    input  logic             mem_ready_i,
    output logic             stall_PC_o,
    output logic             stall_IF_ID_o,
    output logic             stall_ID_EX_o,
    output logic             stall_EX_MEM_o,
    output logic             flush_IF_ID_o,
    output logic             flush_ID_EX_o,
    output logic             bubble_MEM_WB_o,
    output logic             timeout_err_o,
    output logic [1:0]       ctrl_state_o,
    output logic [CNT_W-1:0] stall_cycles_o
);
    localparam int WC_W = $clog2(MEM_WAIT_MAX + 1);
    localparam logic [WC_W-1:0] WC_MAX = WC_W'(MEM_WAIT_MAX);
    typedef enum logic [1:0] {RUN = 2'b00, MEM_WAIT = 2'b01, TIMEOUT = 2'b10} state_t;
    state_t           state_q, state_d;
    logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             load_use, mem_hold, freeze, act, lu_stall;
    // freeze covers every cycle the whole front end must hold; act is when branch/jump/load-use may fire
    always_comb begin
        load_use = MemRead_EX_i && (Rw_EX_i != 5'd0) && (Rw_EX_i == Rs_ID_i || Rw_EX_i == Rt_ID_i);
        mem_hold = mem_req_MEM_i && !mem_ready_i;
        freeze   = rst_n && (state_q == TIMEOUT || (state_q == MEM_WAIT && !mem_ready_i) ||
                             (state_q == RUN && mem_hold));
        act      = rst_n && !freeze;
        lu_stall = act && load_use && !Branch_EX_i;
    end
    assign stall_PC_o      = freeze || lu_stall;
    assign stall_IF_ID_o   = freeze || lu_stall;
    assign stall_ID_EX_o   = freeze;
    assign stall_EX_MEM_o  = freeze;
    assign flush_IF_ID_o   = act && (Branch_EX_i || Jump_ID_i);
    assign flush_ID_EX_o   = (act && Branch_EX_i) || lu_stall;
    assign bubble_MEM_WB_o = freeze;
    assign timeout_err_o   = timeout_q;
    assign ctrl_state_o    = state_q;
    assign stall_cycles_o  = stall_cnt_q;
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        timeout_d   = timeout_q;
        stall_cnt_d = (stall_PC_o && stall_cnt_q != '1) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
        case (state_q)
            RUN: if (mem_hold) begin
                state_d    = MEM_WAIT;
                wait_cnt_d = WC_W'(1);
            end
            MEM_WAIT: if (mem_ready_i) begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end else if (wait_cnt_q == WC_MAX) begin
                state_d   = TIMEOUT;
                timeout_d = 1'b1;
            end else begin
                wait_cnt_d = wait_cnt_q + WC_W'(1);
            end
            default: state_d = TIMEOUT;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
endmodule
